nsu_vc_scheduler: RTL

NSU_VC_SCHEDULER -- requirements
Module: nsu_vc_scheduler

---
 rtl/nsu_vc_scheduler_pkg.sv | 19 +
 rtl/nsu_vc_scheduler_if.sv | 25 ++
 rtl/nsu_vc_scheduler_rr_pick.sv | 33 +++
 rtl/nsu_vc_scheduler.sv | 109 ++++++++++
 4 files changed

// File: rtl/nsu_vc_scheduler_pkg.sv
// Shared NSU constants, index-width helper and scheduler state encoding.
// Imported by the scheduler, the reorder buffer and the depacketizer.
package nsu_vc_scheduler_pkg;

    localparam int NSU_VC_NUM = 16;

    function automatic int vc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NSU_VC_IDX_W = vc_idx_w(NSU_VC_NUM);

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_GRANT = 2'd1,
        SCHED_BUSY  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/nsu_vc_scheduler_if.sv
// Grant handshake between the VC scheduler (master) and the depacketizer (slave).
// pack_done travels back on the same bundle to close out a grant.
interface nsu_vc_scheduler_if
    import nsu_vc_scheduler_pkg::*;
#(
    parameter int VIRTUAL_CH_NUM = NSU_VC_NUM
) ();
    localparam int VC_IDX_W = vc_idx_w(VIRTUAL_CH_NUM);

    logic                      sched_valid;
    logic [VIRTUAL_CH_NUM-1:0] sched_vc;
    logic [VC_IDX_W-1:0]       sched_idx;
    logic                      sched_ready;
    logic                      pack_done;

    modport master (
        output sched_valid, sched_vc, sched_idx,
        input  sched_ready, pack_done
    );

    modport slave (
        input  sched_valid, sched_vc, sched_idx,
        output sched_ready, pack_done
    );
endinterface

// File: rtl/nsu_vc_scheduler_rr_pick.sv
// Round-robin picker: first requesting VC after last_idx, wrapping at N-1.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Outputs are zero when no VC requests.
module nsu_rr_pick #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     pick_oh,
    output logic [IDX_W-1:0] pick_idx
);
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        logic             found;
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        cidx     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_idx) + k;
            if (cand >= N) cand = cand - N;
            cidx = IDX_W'(cand);
            if (!found && req[cidx]) begin
                found         = 1'b1;
                pick_oh[cidx] = 1'b1;
                pick_idx      = cidx;
            end
        end
    end
endmodule

// File: rtl/nsu_vc_scheduler.sv
// Round-robin VC grant scheduler for the NSU depacketizer; optional BUSY watchdog (NSU_SCHED_WDOG_EN).
// Latency: sched_valid rises 1 cycle after vc_req seen in IDLE; one grant in flight at a time.
// Backpressure: grant held stable until sched_ready; BUSY held until pack_done (or watchdog expiry).
module nsu_vc_scheduler
    import nsu_vc_scheduler_pkg::*;
#(
    parameter int VIRTUAL_CH_NUM = NSU_VC_NUM,
    parameter int WDOG_CYCLES    = 1024
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic [VIRTUAL_CH_NUM-1:0] vc_req,
    nsu_vc_scheduler_if.master        sif,
    output logic [VIRTUAL_CH_NUM-1:0] rd_mask,
    output logic                      sched_busy,
    output logic                      wdog_err
);
    localparam int VC_IDX_W = vc_idx_w(VIRTUAL_CH_NUM);

    sched_state_t              state_q, state_d;
    logic [VC_IDX_W-1:0]       last_q, last_d;
    logic [VC_IDX_W-1:0]       idx_q, idx_d;
    logic [VIRTUAL_CH_NUM-1:0] vc_q, vc_d;
    logic [VIRTUAL_CH_NUM-1:0] pick_oh;
    logic [VC_IDX_W-1:0]       pick_idx;
    logic                      wdog_hit;

    nsu_rr_pick #(
        .N     (VIRTUAL_CH_NUM),
        .IDX_W (VC_IDX_W)
    ) u_rr_pick (
        .req      (vc_req),
        .last_idx (last_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

`ifdef NSU_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              wdog_err_q;

    assign wdog_hit = (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
    assign wdog_err = wdog_err_q;

    // Counter is zero whenever not in BUSY, so it restarts on every BUSY entry.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (state_q != SCHED_BUSY) wdog_cnt_q <= '0;
            else                       wdog_cnt_q <= wdog_cnt_q + 1'b1;
            if (state_q == SCHED_BUSY && !sif.pack_done && wdog_hit) wdog_err_q <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q <= SCHED_IDLE;
            last_q  <= VC_IDX_W'(VIRTUAL_CH_NUM - 1);
            idx_q   <= '0;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            vc_q    <= vc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        vc_d    = vc_q;
        unique case (state_q)
            SCHED_IDLE: begin
                if (|vc_req) begin
                    idx_d   = pick_idx;
                    vc_d    = pick_oh;
                    state_d = SCHED_GRANT;
                end
            end
            SCHED_GRANT: begin
                if (sif.sched_ready) state_d = SCHED_BUSY;
            end
            SCHED_BUSY: begin
                // Timeout retires the grant like a normal completion so round-robin keeps moving.
                if (sif.pack_done || wdog_hit) begin
                    last_d  = idx_q;
                    state_d = SCHED_IDLE;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    assign sif.sched_valid = (state_q == SCHED_GRANT);
    assign sif.sched_vc    = vc_q;
    assign sif.sched_idx   = idx_q;
    assign rd_mask         = (state_q == SCHED_BUSY) ? vc_q : '0;
    assign sched_busy      = (state_q != SCHED_IDLE);
endmodule
